// File: rtl/decode_ctrl_unit.sv
// Decode-stage control: main decoder, branch comparator, immediate extender and sticky illegal flag.
// Optional: define DCU_REGIMM_EN to decode opcode 000001 (bltz/bgez); otherwise that opcode is illegal.
module decode_ctrl_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] ForwardD1,
  input  logic [31:0] ForwardD2,
  output logic [31:0] Imm32,
  output logic        Equal,
  output logic        LTZ,
  output logic        EQZ,
  output logic        NPCOp,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ExtOp,
  output logic [1:0]  A3Sel,
  output logic        GenD,
  output logic        MD,
  output logic        D1Use,
  output logic        D2Use,
  output logic        IllegalNow,
  output logic        Illegal
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  localparam logic [1:0] PCSRC_PC4  = 2'b00;
  localparam logic [1:0] PCSRC_NPC  = 2'b01;
  localparam logic [1:0] PCSRC_RS   = 2'b10;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_HIGH   = 2'b10;

  localparam logic [1:0] A3_NONE    = 2'b00;
  localparam logic [1:0] A3_RA      = 2'b01;
  localparam logic [1:0] A3_RD      = 2'b10;
  localparam logic [1:0] A3_RT      = 2'b11;

  logic [5:0]  op_s;
  logic [4:0]  rt_s;
  logic [5:0]  funct_s;
  logic [15:0] imm16_s;
  logic        equal_s;
  logic        ltz_s;
  logic        eqz_s;
  logic        npc_op_s;
  logic [1:0]  pc_src_s;
  logic [1:0]  ext_op_s;
  logic [1:0]  a3_sel_s;
  logic        gen_d_s;
  logic        md_s;
  logic        d1_use_s;
  logic        d2_use_s;
  logic        illegal_now_s;
  logic        illegal_r;

  // Extension code 11 is never produced by the decoder but falls back to sign-extension.
  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic [1:0] sel);
    logic [31:0] res;
    case (sel)
      EXT_ZERO: res = {16'h0000, imm};
      EXT_HIGH: res = {imm, 16'h0000};
      default:  res = {{16{imm[15]}}, imm};
    endcase
    return res;
  endfunction

  function automatic logic [1:0] take_if(input logic cond);
    logic [1:0] res;
    if (cond) begin
      res = PCSRC_NPC;
    end else begin
      res = PCSRC_PC4;
    end
    return res;
  endfunction

  assign op_s    = InstrD[31:26];
  assign rt_s    = InstrD[20:16];
  assign funct_s = InstrD[5:0];
  assign imm16_s = InstrD[15:0];

  // Branch comparator on the forwarded register values.
  always_comb begin
    equal_s = (ForwardD1 == ForwardD2);
    ltz_s   = ForwardD1[31];
    eqz_s   = (ForwardD1 == 32'h0000_0000);
  end

  // Main decoder: every path starts from the defaults and only overrides what it needs.
  always_comb begin
    npc_op_s      = 1'b0;
    pc_src_s      = PCSRC_PC4;
    ext_op_s      = EXT_SIGN;
    a3_sel_s      = A3_NONE;
    gen_d_s       = 1'b0;
    md_s          = 1'b0;
    d1_use_s      = 1'b0;
    d2_use_s      = 1'b0;
    illegal_now_s = 1'b0;
    case (op_s)
      OP_SPECIAL: begin
        case (funct_s)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
            a3_sel_s = A3_RD;
          end
          FN_MFHI, FN_MFLO: begin
            a3_sel_s = A3_RD;
            md_s     = 1'b1;
          end
          FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            md_s = 1'b1;
          end
          FN_JR: begin
            pc_src_s = PCSRC_RS;
            d1_use_s = 1'b1;
          end
          FN_JALR: begin
            pc_src_s = PCSRC_RS;
            d1_use_s = 1'b1;
            a3_sel_s = A3_RD;
            gen_d_s  = 1'b1;
          end
          default: begin
            illegal_now_s = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        a3_sel_s = A3_RT;
        ext_op_s = EXT_SIGN;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        a3_sel_s = A3_RT;
        ext_op_s = EXT_ZERO;
      end
      OP_LUI: begin
        a3_sel_s = A3_RT;
        ext_op_s = EXT_HIGH;
      end
      OP_SB, OP_SH, OP_SW: begin
        ext_op_s = EXT_SIGN;
      end
      OP_BEQ: begin
        d1_use_s = 1'b1;
        d2_use_s = 1'b1;
        pc_src_s = take_if(equal_s);
      end
      OP_BNE: begin
        d1_use_s = 1'b1;
        d2_use_s = 1'b1;
        pc_src_s = take_if(!equal_s);
      end
      OP_BLEZ: begin
        d1_use_s = 1'b1;
        pc_src_s = take_if(ltz_s | eqz_s);
      end
      OP_BGTZ: begin
        d1_use_s = 1'b1;
        pc_src_s = take_if(!(ltz_s | eqz_s));
      end
`ifdef DCU_REGIMM_EN
      OP_REGIMM: begin
        case (rt_s)
          RT_BLTZ: begin
            d1_use_s = 1'b1;
            pc_src_s = take_if(ltz_s);
          end
          RT_BGEZ: begin
            d1_use_s = 1'b1;
            pc_src_s = take_if(!ltz_s);
          end
          default: begin
            illegal_now_s = 1'b1;
          end
        endcase
      end
`else
      OP_REGIMM: begin
        illegal_now_s = 1'b1;
      end
`endif
      OP_J: begin
        npc_op_s = 1'b1;
        pc_src_s = PCSRC_NPC;
      end
      OP_JAL: begin
        npc_op_s = 1'b1;
        pc_src_s = PCSRC_NPC;
        a3_sel_s = A3_RA;
        gen_d_s  = 1'b1;
      end
      default: begin
        illegal_now_s = 1'b1;
      end
    endcase
  end

  // Sticky illegal flag; reset has priority over a simultaneous illegal instruction.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_r | illegal_now_s;
    end
  end

  assign Imm32      = extend_imm(imm16_s, ext_op_s);
  assign Equal      = equal_s;
  assign LTZ        = ltz_s;
  assign EQZ        = eqz_s;
  assign NPCOp      = npc_op_s;
  assign PCSrc      = pc_src_s;
  assign ExtOp      = ext_op_s;
  assign A3Sel      = a3_sel_s;
  assign GenD       = gen_d_s;
  assign MD         = md_s;
  assign D1Use      = d1_use_s;
  assign D2Use      = d2_use_s;
  assign IllegalNow = illegal_now_s;
  assign Illegal    = illegal_r;

endmodule

// File: tb/tb_decode_ctrl_unit.sv
// Self-checking bench for decode_ctrl_unit: directed cases plus randomized instructions
// checked against a table-driven instruction-class model. Honours DCU_REGIMM_EN.
module tb_decode_ctrl_unit;

  logic        Clk;
  logic        Reset;
  logic [31:0] InstrD, ForwardD1, ForwardD2;
  logic [31:0] Imm32;
  logic        Equal, LTZ, EQZ, NPCOp, GenD, MD, D1Use, D2Use, IllegalNow, Illegal;
  logic [1:0]  PCSrc, ExtOp, A3Sel;

  decode_ctrl_unit dut (
    .Clk(Clk), .Reset(Reset), .InstrD(InstrD), .ForwardD1(ForwardD1), .ForwardD2(ForwardD2),
    .Imm32(Imm32), .Equal(Equal), .LTZ(LTZ), .EQZ(EQZ), .NPCOp(NPCOp), .PCSrc(PCSrc),
    .ExtOp(ExtOp), .A3Sel(A3Sel), .GenD(GenD), .MD(MD), .D1Use(D1Use), .D2Use(D2Use),
    .IllegalNow(IllegalNow), .Illegal(Illegal)
  );

`ifdef DCU_REGIMM_EN
  localparam bit REGIMM_EN = 1'b1;
`else
  localparam bit REGIMM_EN = 1'b0;
`endif

  typedef struct packed {
    logic       npc;
    logic [1:0] pcsrc;
    logic [1:0] ext;
    logic [1:0] a3;
    logic       gend;
    logic       md;
    logic       d1u;
    logic       d2u;
    logic       ill;
  } ctl_t;

  int checks = 0;
  int failures = 0;
  logic ill_m = 1'b0;
  string fn_cls[logic [5:0]];
  string op_cls[logic [5:0]];
  logic [5:0] fn_keys[$];
  logic [5:0] op_keys[$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic build_tables();
    fn_cls[6'h21] = "alu"; fn_cls[6'h23] = "alu"; fn_cls[6'h24] = "alu"; fn_cls[6'h25] = "alu";
    fn_cls[6'h26] = "alu"; fn_cls[6'h27] = "alu"; fn_cls[6'h2a] = "alu"; fn_cls[6'h2b] = "alu";
    fn_cls[6'h00] = "alu"; fn_cls[6'h02] = "alu"; fn_cls[6'h03] = "alu"; fn_cls[6'h04] = "alu";
    fn_cls[6'h06] = "alu"; fn_cls[6'h07] = "alu";
    fn_cls[6'h10] = "mfhl"; fn_cls[6'h12] = "mfhl";
    fn_cls[6'h11] = "mtmd"; fn_cls[6'h13] = "mtmd"; fn_cls[6'h18] = "mtmd";
    fn_cls[6'h19] = "mtmd"; fn_cls[6'h1a] = "mtmd"; fn_cls[6'h1b] = "mtmd";
    fn_cls[6'h08] = "jr";   fn_cls[6'h09] = "jalr";
    op_cls[6'h08] = "isx"; op_cls[6'h09] = "isx"; op_cls[6'h0a] = "isx"; op_cls[6'h0b] = "isx";
    op_cls[6'h20] = "isx"; op_cls[6'h21] = "isx"; op_cls[6'h23] = "isx"; op_cls[6'h24] = "isx";
    op_cls[6'h25] = "isx";
    op_cls[6'h0c] = "izx"; op_cls[6'h0d] = "izx"; op_cls[6'h0e] = "izx"; op_cls[6'h0f] = "lui";
    op_cls[6'h28] = "st";  op_cls[6'h29] = "st";  op_cls[6'h2b] = "st";
    op_cls[6'h04] = "beq"; op_cls[6'h05] = "bne"; op_cls[6'h06] = "blez"; op_cls[6'h07] = "bgtz";
    op_cls[6'h02] = "j";   op_cls[6'h03] = "jal";
    foreach (fn_cls[k]) fn_keys.push_back(k);
    foreach (op_cls[k]) op_keys.push_back(k);
  endtask

  // Reference: classify the instruction, then apply that class's control rules.
  function automatic ctl_t ref_ctl(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    ctl_t c;
    string cls;
    logic taken;
    c = '{npc: 1'b0, pcsrc: 2'd0, ext: 2'd1, a3: 2'd0, gend: 1'b0, md: 1'b0,
          d1u: 1'b0, d2u: 1'b0, ill: 1'b0};
    cls = "";
    taken = 1'b0;
    if (i[31:26] == 6'd0) begin
      if (fn_cls.exists(i[5:0])) cls = fn_cls[i[5:0]];
    end else if (i[31:26] == 6'd1) begin
      if (REGIMM_EN && i[20:16] == 5'd0) cls = "bltz";
      else if (REGIMM_EN && i[20:16] == 5'd1) cls = "bgez";
    end else if (op_cls.exists(i[31:26])) begin
      cls = op_cls[i[31:26]];
    end
    if (cls == "") c.ill = 1'b1;
    else if (cls == "alu")  c.a3 = 2'd2;
    else if (cls == "mfhl") begin c.a3 = 2'd2; c.md = 1'b1; end
    else if (cls == "mtmd") c.md = 1'b1;
    else if (cls == "jr")   begin c.pcsrc = 2'd2; c.d1u = 1'b1; end
    else if (cls == "jalr") begin c.pcsrc = 2'd2; c.d1u = 1'b1; c.a3 = 2'd2; c.gend = 1'b1; end
    else if (cls == "isx")  c.a3 = 2'd3;
    else if (cls == "izx")  begin c.a3 = 2'd3; c.ext = 2'd0; end
    else if (cls == "lui")  begin c.a3 = 2'd3; c.ext = 2'd2; end
    else if (cls == "j")    begin c.npc = 1'b1; c.pcsrc = 2'd1; end
    else if (cls == "jal")  begin c.npc = 1'b1; c.pcsrc = 2'd1; c.a3 = 2'd1; c.gend = 1'b1; end
    else if (cls != "st") begin
      c.d1u = 1'b1;
      if (cls == "beq")       begin taken = (a == b); c.d2u = 1'b1; end
      else if (cls == "bne")  begin taken = (a != b); c.d2u = 1'b1; end
      else if (cls == "blez") taken = ($signed(a) <= 0);
      else if (cls == "bgtz") taken = ($signed(a) > 0);
      else if (cls == "bltz") taken = ($signed(a) < 0);
      else                    taken = ($signed(a) >= 0);
      c.pcsrc = taken ? 2'd1 : 2'd0;
    end
    return c;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [15:0] imm, input logic [1:0] ext);
    if (ext == 2'd0) return 32'(imm);
    if (ext == 2'd2) return 32'(imm) * 32'd65536;
    return 32'($signed(imm));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic rst);
    ctl_t e;
    @(negedge Clk);
    InstrD = i; ForwardD1 = a; ForwardD2 = b; Reset = rst;
    #1;
    e = ref_ctl(i, a, b);
    chk("Equal", 32'(Equal), 32'(a == b));
    chk("LTZ", 32'(LTZ), 32'($signed(a) < 0));
    chk("EQZ", 32'(EQZ), 32'(a == 32'd0));
    chk("NPCOp", 32'(NPCOp), 32'(e.npc));
    chk("PCSrc", 32'(PCSrc), 32'(e.pcsrc));
    chk("ExtOp", 32'(ExtOp), 32'(e.ext));
    chk("A3Sel", 32'(A3Sel), 32'(e.a3));
    chk("GenD", 32'(GenD), 32'(e.gend));
    chk("MD", 32'(MD), 32'(e.md));
    chk("D1Use", 32'(D1Use), 32'(e.d1u));
    chk("D2Use", 32'(D2Use), 32'(e.d2u));
    chk("IllegalNow", 32'(IllegalNow), 32'(e.ill));
    chk("Imm32", Imm32, ref_imm(i[15:0], e.ext));
    @(posedge Clk);
    ill_m = rst ? (ill_m | e.ill) : 1'b0;
    #1;
    chk("Illegal", 32'(Illegal), 32'(ill_m));
  endtask

  initial begin
    logic [31:0] ins, a, b;
    int pick;
    build_tables();
    Reset = 1'b0; InstrD = 32'd0; ForwardD1 = 32'd0; ForwardD2 = 32'd0;
    apply(32'hFC00_0000, 32'd0, 32'd0, 1'b0);
    chk("reset_illegal", 32'(Illegal), 32'd0);

    apply({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234, 1'b1);
    chk("beq_taken", 32'(PCSrc), 32'd1);
    apply({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1235, 1'b1);
    chk("beq_not_taken", 32'(PCSrc), 32'd0);

    apply({6'h01, 5'd1, 5'd1, 16'h0010}, 32'h8000_0000, 32'd7, 1'b1);
`ifdef DCU_REGIMM_EN
    chk("bgez_neg", 32'(PCSrc), 32'd0);
    apply({6'h01, 5'd1, 5'd1, 16'h0010}, 32'd0, 32'd7, 1'b1);
    chk("bgez_zero", 32'(PCSrc), 32'd1);
`else
    chk("regimm_illegal", 32'(IllegalNow), 32'd1);
`endif
    apply(32'd0, 32'd0, 32'd0, 1'b0);

    apply({6'h0f, 5'd0, 5'd3, 16'hABCD}, 32'd1, 32'd2, 1'b1);
    chk("lui_imm", Imm32, 32'hABCD_0000);
    apply({6'h0d, 5'd1, 5'd3, 16'h8001}, 32'd1, 32'd2, 1'b1);
    chk("ori_imm", Imm32, 32'h0000_8001);
    apply({6'h23, 5'd1, 5'd3, 16'h8001}, 32'd1, 32'd2, 1'b1);
    chk("lw_imm", Imm32, 32'hFFFF_8001);
    apply({6'h03, 26'h000_0100}, 32'd1, 32'd2, 1'b1);
    chk("jal_a3", 32'(A3Sel), 32'd1);
    apply({6'h00, 5'd1, 5'd0, 5'd31, 5'd0, 6'h09}, 32'd1, 32'd2, 1'b1);
    chk("jalr_pcsrc", 32'(PCSrc), 32'd2);
    apply({6'h00, 5'd1, 5'd2, 10'd0, 6'h18}, 32'd1, 32'd2, 1'b1);
    chk("mult_md", 32'(MD), 32'd1);
    apply({6'h00, 10'd0, 5'd4, 5'd0, 6'h12}, 32'd1, 32'd2, 1'b1);
    chk("mflo_a3", 32'(A3Sel), 32'd2);
    apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd1, 32'd2, 1'b1);
    chk("addu_md", 32'(MD), 32'd0);
    chk("legal_no_sticky", 32'(Illegal), 32'd0);

    apply(32'hFC00_0000, 32'd1, 32'd2, 1'b1);
    chk("sticky_set", 32'(Illegal), 32'd1);
    apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd1, 32'd2, 1'b1);
    chk("sticky_hold", 32'(Illegal), 32'd1);
    apply(32'hFC00_0000, 32'd1, 32'd2, 1'b0);
    chk("reset_wins", 32'(Illegal), 32'd0);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      pick = $urandom_range(0, 9);
      if (pick < 4) begin
        ins[31:26] = 6'd0;
        ins[5:0] = fn_keys[$urandom_range(0, fn_keys.size() - 1)];
      end else if (pick < 8) begin
        ins[31:26] = op_keys[$urandom_range(0, op_keys.size() - 1)];
      end else if (pick == 8) begin
        ins[31:26] = 6'd1;
        ins[20:16] = 5'($urandom_range(0, 2));
      end
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        default: a = a;
      endcase
      b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
      apply(ins, a, b, ($urandom_range(0, 19) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_unit.md
# decode_ctrl_unit

Decode-stage control unit of the five-stage MIPS pipeline. It combines the main instruction decoder, the branch comparator and the 16-to-32-bit immediate extender. It sits between the F/D pipeline register and the D/E register. It drives next-PC selection, write-register selection, hazard-use flags and the extended immediate. It also keeps a sticky illegal-instruction flag.

## Interface
Parameters: none.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  reset, synchronous and active-low (Reset=0 resets on the next rising Clk edge).
- InstrD  in  32  instruction in D stage.
- ForwardD1  in  32  forwarded rs value.
- ForwardD2  in  32  forwarded rt value.
- Imm32  out  32  extended immediate.
- Equal  out  1  ForwardD1 == ForwardD2.
- LTZ  out  1  ForwardD1 signed < 0.
- EQZ  out  1  ForwardD1 == 0.
- NPCOp  out  1  0 = branch target (PC4 + sext(imm16)<<2); 1 = jump target {PC4[31:28], imm26, 2'b00}.
- PCSrc  out  2  00 = PC+4; 01 = NPC output; 10 = rs register; 11 is never driven.
- ExtOp  out  2  00 = zero-extend; 01 = sign-extend; 10 = imm16<<16; 11 behaves like 01.
- A3Sel  out  2  00 = $0 (no write); 01 = $31; 10 = rd; 11 = rt.
- GenD  out  1  write data is PC+8, produced in D.
- MD  out  1  multiply/divide-unit instruction.
- D1Use  out  1  rs consumed in D stage.
- D2Use  out  1  rt consumed in D stage.
- IllegalNow  out  1  current InstrD is undecodable.
- Illegal  out  1  sticky registered illegal flag.

## Operation
- The comparator, the extender and the decoder are purely combinational on InstrD, ForwardD1 and ForwardD2.
- Fields: op = [31:26], rt = [20:16], funct = [5:0].

Special opcode 000000 (decoded on funct):
- ALU ops, A3Sel=10: addu 100001, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111.
- mfhi 010000, mflo 010010: A3Sel=10, MD=1.
- mthi 010001, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011: A3Sel=00, MD=1.
- jr 001000: PCSrc=10, D1Use=1.
- jalr 001001: PCSrc=10, D1Use=1, A3Sel=10, GenD=1.

I-type ALU and load instructions, A3Sel=11:
- Sign-extended (ExtOp=01): addi, addiu, slti, sltiu, lb, lh, lw, lbu, lhu.
- Zero-extended (ExtOp=00): andi, ori, xori.
- lui: ExtOp=10.

Stores (sb, sh, sw): A3Sel=00, ExtOp=01.

Branches: NPCOp=0, D1Use=1; PCSrc=01 when taken, else 00.
- beq: taken on Equal; D2Use=1.
- bne: taken on !Equal; D2Use=1.
- blez: taken on LTZ|EQZ.
- bgtz: taken on !(LTZ|EQZ).
- Opcode 000001 with rt=00000 (bltz): taken on LTZ.
- Opcode 000001 with rt=00001 (bgez): taken on !LTZ.

Jumps:
- j: NPCOp=1, PCSrc=01.
- jal: NPCOp=1, PCSrc=01, A3Sel=01, GenD=1.

Defaults:
- Any output not listed for an instruction takes its default: NPCOp=0, PCSrc=00, ExtOp=01, A3Sel=00, GenD=MD=D1Use=D2Use=0.
- Any other op, funct or rt combination sets IllegalNow=1 with all controls at their defaults.

## Timing
- All outputs except Illegal are combinational; they settle within the same cycle.
- Illegal updates on the rising Clk edge:
  - Reset=0: Illegal becomes 0.
  - Otherwise: Illegal becomes Illegal | IllegalNow.
- After reset, Illegal is 0; the combinational outputs have no reset state and follow their inputs.
- Reset asserted in the same cycle as an illegal instruction: Illegal becomes 0, because reset wins.
- A stalled instruction held in D re-asserts IllegalNow each cycle; the sticky value is unaffected.

## Configuration
- Macro DCU_REGIMM_EN.
- Defined: opcode 000001 decodes bltz and bgez as above.
- Undefined: opcode 000001 is illegal (IllegalNow=1, all controls at defaults).

## Test plan
- beq, ForwardD1=ForwardD2=0x1234: Equal=1, PCSrc=01, NPCOp=0, D1Use=D2Use=1. Repeat with ForwardD2=0x1235: PCSrc=00.
- bgez (DCU_REGIMM_EN defined), ForwardD1=0x80000000: LTZ=1, PCSrc=00. Repeat with ForwardD1=0: EQZ=1, PCSrc=01. With DCU_REGIMM_EN undefined: IllegalNow=1.
- lui imm=0xABCD: Imm32=0xABCD0000, A3Sel=11. ori imm=0x8001: Imm32=0x00008001. lw imm=0x8001: Imm32=0xFFFF8001.
- jal: A3Sel=01, GenD=1, NPCOp=1, PCSrc=01. jalr: A3Sel=10, GenD=1, PCSrc=10.
- mult: MD=1, A3Sel=00. mflo: MD=1, A3Sel=10. addu: MD=0, A3Sel=10.
- Instruction 0xFC000000: IllegalNow=1, Illegal=1 after the next edge and it stays 1 for following legal instructions. Reset=0 for one edge: Illegal=0.
